// File: rtl/core_pkg.sv
// Shared core definitions: register address width default, forwarding select
// encoding and the result-source code that marks a load.
package core_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RES_SRC_MEM = 2'b01;

endpackage

// File: rtl/mc_scoreboard.sv
// In-order FIFO of in-flight multi-cycle writes with per-entry countdown,
// head write-back and destination match against NUM_Q query addresses.
module mc_scoreboard
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MC_LAT     = 4,
    parameter int MC_DEPTH   = 4,
    parameter int NUM_Q      = 3,
    parameter int PTR_W      = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1,
    parameter int OCC_W      = $clog2(MC_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue,
    input  logic [REG_ADDR_W-1:0]       issue_rd,
    input  logic [NUM_Q*REG_ADDR_W-1:0] query,
    output logic [NUM_Q-1:0]            match,
    output logic [OCC_W-1:0]            occupancy,
    output logic                        busy,
    output logic                        wb_valid,
    output logic [REG_ADDR_W-1:0]       wb_rd
);

    logic                  valid_r [MC_DEPTH];
    logic [REG_ADDR_W-1:0] rd_r    [MC_DEPTH];
    logic [3:0]            cnt_r   [MC_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      occ_r;

    logic full_s;
    logic retire_s;
    logic alloc_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MC_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_s   = (occ_r == OCC_W'(MC_DEPTH));
    assign retire_s = valid_r[rd_ptr_r] && (cnt_r[rd_ptr_r] == 4'd0);
    // An issue into a full FIFO is a protocol error; leave state untouched.
    assign alloc_s  = issue && !full_s;

    assign occupancy = occ_r;
    assign busy      = (occ_r != {OCC_W{1'b0}});
    assign wb_valid  = retire_s;
    assign wb_rd     = retire_s ? rd_r[rd_ptr_r] : {REG_ADDR_W{1'b0}};

    // FIFO state: countdown, retire at head, allocate at tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < MC_DEPTH; e++) begin
                valid_r[e] <= 1'b0;
                rd_r[e]    <= {REG_ADDR_W{1'b0}};
                cnt_r[e]   <= 4'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            for (int e = 0; e < MC_DEPTH; e++) begin
                if (valid_r[e] && (cnt_r[e] != 4'd0)) begin
                    cnt_r[e] <= cnt_r[e] - 4'd1;
                end
            end
            if (retire_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ptr_inc(rd_ptr_r);
            end
            if (alloc_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                rd_r[wr_ptr_r]    <= issue_rd;
                cnt_r[wr_ptr_r]   <= 4'(MC_LAT - 1);
                wr_ptr_r          <= ptr_inc(wr_ptr_r);
            end
            case ({alloc_s, retire_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Destination match of every query address against all valid entries.
    always_comb begin
        match = {NUM_Q{1'b0}};
        for (int q = 0; q < NUM_Q; q++) begin
            for (int e = 0; e < MC_DEPTH; e++) begin
                if (valid_r[e] && (rd_r[e] == query[q*REG_ADDR_W +: REG_ADDR_W])) begin
                    match[q] = 1'b1;
                end else begin
                    match[q] = match[q];
                end
            end
        end
    end

    mc_scoreboard_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (issue),
        .full  (full_s)
    );

endmodule

// File: rtl/mc_scoreboard_chk.sv
// Protocol checker for the MCU scoreboard: the EX stage must never issue into
// a full scoreboard.
module mc_scoreboard_chk (
    input logic clk,
    input logic rst_n,
    input logic issue,
    input logic full
);

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(issue && full));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core with MCU: MEM/WB forwarding, load-use and
// MCU scoreboard stalls, branch flushes.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_SRC    = 2,
    parameter int MC_LAT     = 4,
    parameter int MC_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] de_rs,
    input  logic [REG_ADDR_W-1:0]         de_rd,
    input  logic                          de_reg_write,
    input  logic                          de_is_mc,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_reg_write,
    input  logic [1:0]                    ex_result_src,
    input  logic                          ex_pc_src,
    input  logic                          ex_mc_issue,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          mem_reg_write,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          wb_reg_write,
    output logic                          if_stall,
    output logic                          de_stall,
    output logic                          de_flush,
    output logic                          ex_flush,
    output logic [NUM_SRC*2-1:0]          ex_fwd,
    output logic                          mc_busy,
    output logic                          mc_wb_valid,
    output logic [REG_ADDR_W-1:0]         mc_wb_rd
);

    localparam int OCC_W = $clog2(MC_DEPTH + 1);

    logic [NUM_SRC:0]   sb_match_s;
    logic [OCC_W-1:0]   sb_occ_s;
    logic               load_stall_s;
    logic               mc_raw_s;
    logic               mc_waw_s;
    logic               mc_full_s;
    logic               stall_s;

    mc_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MC_LAT     (MC_LAT),
        .MC_DEPTH   (MC_DEPTH),
        .NUM_Q      (NUM_SRC + 1)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (ex_mc_issue),
        .issue_rd  (ex_rd),
        .query     ({de_rd, de_rs}),
        .match     (sb_match_s),
        .occupancy (sb_occ_s),
        .busy      (mc_busy),
        .wb_valid  (mc_wb_valid),
        .wb_rd     (mc_wb_rd)
    );

    // Operand forwarding; MEM wins over WB, register 0 never forwards.
    always_comb begin
        ex_fwd = {NUM_SRC*2{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((ex_rs[i*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}}) && mem_reg_write &&
                (ex_rs[i*REG_ADDR_W +: REG_ADDR_W] == mem_rd)) begin
                ex_fwd[i*2 +: 2] = FWD_MEM;
            end else if ((ex_rs[i*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}}) && wb_reg_write &&
                         (ex_rs[i*REG_ADDR_W +: REG_ADDR_W] == wb_rd)) begin
                ex_fwd[i*2 +: 2] = FWD_WB;
            end else begin
                ex_fwd[i*2 +: 2] = FWD_RF;
            end
        end
    end

    // Load-use and MCU RAW detection per decode source operand.
    always_comb begin
        load_stall_s = 1'b0;
        mc_raw_s     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((ex_result_src == RES_SRC_MEM) && ex_reg_write && (ex_rd != {REG_ADDR_W{1'b0}}) &&
                (de_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)) begin
                load_stall_s = 1'b1;
            end else begin
                load_stall_s = load_stall_s;
            end
            if ((de_rs[i*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}}) &&
                (sb_match_s[i] || (ex_mc_issue && (de_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)))) begin
                mc_raw_s = 1'b1;
            end else begin
                mc_raw_s = mc_raw_s;
            end
        end
    end

    // Same-cycle retire is deliberately not credited against the full check.
    assign mc_waw_s  = de_reg_write && (de_rd != {REG_ADDR_W{1'b0}}) &&
                       (sb_match_s[NUM_SRC] || (ex_mc_issue && (de_rd == ex_rd)));
    assign mc_full_s = de_is_mc &&
                       (({1'b0, sb_occ_s} + {{OCC_W{1'b0}}, ex_mc_issue}) == (OCC_W+1)'(MC_DEPTH));
    assign stall_s   = load_stall_s || mc_raw_s || mc_waw_s || mc_full_s;

    assign if_stall = stall_s && !ex_pc_src;
    assign de_stall = stall_s && !ex_pc_src;
    assign de_flush = ex_pc_src;
    assign ex_flush = stall_s || ex_pc_src;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (defaults: 5-bit regs, 2 sources,
// MC_LAT=4, MC_DEPTH=4) with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  de_rs;
    logic [4:0]  de_rd;
    logic        de_reg_write;
    logic        de_is_mc;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [1:0]  ex_result_src;
    logic        ex_pc_src;
    logic        ex_mc_issue;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        if_stall;
    logic        de_stall;
    logic        de_flush;
    logic        ex_flush;
    logic [3:0]  ex_fwd;
    logic        mc_busy;
    logic        mc_wb_valid;
    logic [4:0]  mc_wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .de_rs         (de_rs),
        .de_rd         (de_rd),
        .de_reg_write  (de_reg_write),
        .de_is_mc      (de_is_mc),
        .ex_rs         (ex_rs),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_result_src (ex_result_src),
        .ex_pc_src     (ex_pc_src),
        .ex_mc_issue   (ex_mc_issue),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .if_stall      (if_stall),
        .de_stall      (de_stall),
        .de_flush      (de_flush),
        .ex_flush      (ex_flush),
        .ex_fwd        (ex_fwd),
        .mc_busy       (mc_busy),
        .mc_wb_valid   (mc_wb_valid),
        .mc_wb_rd      (mc_wb_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_rs = 10'd0; de_rd = 5'd0; de_reg_write = 1'b0; de_is_mc = 1'b0;
        ex_rs = 10'd0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_result_src = 2'b00;
        ex_pc_src = 1'b0; ex_mc_issue = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_wb_valid", 32'(mc_wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(mc_wb_rd), 32'd0);
        chk("rst_stall", 32'({if_stall, de_stall, de_flush, ex_flush}), 32'd0);
        rst_n = 1'b1;
        tick();

        // forwarding priority and register-0 exclusion
        ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1 chk("fwd_mem", 32'(ex_fwd), 32'h2);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", 32'(ex_fwd), 32'h1);
        ex_rs = {5'd0, 5'd0}; wb_rd = 5'd0;
        #1 chk("fwd_zero", 32'(ex_fwd), 32'h0);
        ex_rs = {5'd6, 5'd4}; mem_rd = 5'd4; mem_reg_write = 1'b1; wb_rd = 5'd6; wb_reg_write = 1'b1;
        #1 chk("fwd_both_ops", 32'(ex_fwd), 32'h6);
        clear_inputs();

        // load-use stall for one cycle
        ex_result_src = 2'b01; ex_reg_write = 1'b1; ex_rd = 5'd7; de_rs = {5'd7, 5'd0};
        #1 chk("load_stall", 32'({if_stall, de_stall, de_flush, ex_flush}), 32'hD);
        tick();
        ex_result_src = 2'b00; ex_reg_write = 1'b0; ex_rd = 5'd0;
        #1 chk("load_release", 32'({if_stall, de_stall, ex_flush}), 32'd0);
        ex_result_src = 2'b01; ex_reg_write = 1'b1; ex_rd = 5'd0; de_rs = {5'd0, 5'd0};
        #1 chk("load_rd0", 32'({if_stall, de_stall, ex_flush}), 32'd0);
        clear_inputs();
        tick();

        // single MCU op, latency 4
        ex_mc_issue = 1'b1; ex_rd = 5'd9; de_rs = {5'd0, 5'd9};
        #1 chk("mc_issue_raw", 32'(de_stall), 32'd1);
        for (int c = 0; c <= 4; c++) begin
            tick();
            ex_mc_issue = 1'b0; ex_rd = 5'd0;
            #1;
            chk($sformatf("mc_wbv_c%0d", c), 32'(mc_wb_valid), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("mc_wbrd_c%0d", c), 32'(mc_wb_rd), (c == 3) ? 32'd9 : 32'd0);
            chk($sformatf("mc_raw_c%0d", c), 32'(de_stall), (c < 4) ? 32'd1 : 32'd0);
        end
        chk("mc_idle", 32'(mc_busy), 32'd0);
        clear_inputs();

        // fill scoreboard, full stall, in-order retire
        de_is_mc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex_mc_issue = 1'b1; ex_rd = 5'(10 + k);
            #1 chk($sformatf("full_issue%0d", k), 32'(de_stall), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        ex_mc_issue = 1'b0; ex_rd = 5'd0;
        #1 chk("full_hold", 32'(de_stall), 32'd1);
        chk("full_ret0", 32'({mc_wb_valid, mc_wb_rd}), 32'h2A);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("full_rel%0d", k), 32'(de_stall), 32'd0);
            chk($sformatf("full_ret%0d", k), 32'({mc_wb_valid, mc_wb_rd}), 32'(32 + 10 + k));
            chk($sformatf("full_busy%0d", k), 32'(mc_busy), 32'd1);
        end
        tick();
        chk("full_empty", 32'({mc_busy, mc_wb_valid}), 32'd0);
        clear_inputs();

        // branch overrides MCU RAW stall, op still retires
        ex_mc_issue = 1'b1; ex_rd = 5'd3;
        tick();
        ex_mc_issue = 1'b0; ex_rd = 5'd0; de_rs = {5'd0, 5'd3}; ex_pc_src = 1'b1;
        #1 chk("br_stall", 32'({if_stall, de_stall}), 32'd0);
        chk("br_flush", 32'({de_flush, ex_flush}), 32'h3);
        tick();
        ex_pc_src = 1'b0; de_rs = 10'd0;
        tick();
        chk("br_pending", 32'(mc_wb_valid), 32'd0);
        tick();
        chk("br_retire", 32'({mc_wb_valid, mc_wb_rd}), 32'h23);
        tick();
        clear_inputs();

        // WAW stall, then reset with three ops in flight
        for (int k = 0; k < 3; k++) begin
            ex_mc_issue = 1'b1; ex_rd = 5'(20 + k);
            tick();
        end
        ex_mc_issue = 1'b0; ex_rd = 5'd0; de_reg_write = 1'b1; de_rd = 5'd20;
        #1 chk("waw_stall", 32'(de_stall), 32'd1);
        rst_n = 1'b0;
        #1 chk("midrst_busy", 32'(mc_busy), 32'd0);
        chk("midrst_wbv", 32'(mc_wb_valid), 32'd0);
        chk("midrst_waw", 32'(de_stall), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post_rst_c%0d", c), 32'({mc_busy, mc_wb_valid}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
